// File: rtl/itof_pipe.sv
// Pipelined signed int32 -> IEEE-754 single converter.
// Four register levels (sign/mag, normalize, round, pack); a stalled output freezes every stage.
module itof_pipe #(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        x_valid,
  output logic        x_ready,
  output logic [31:0] y,
  output logic        y_valid,
  input  logic        y_ready
);

  logic        stall;

  // vld_pipe bit k is the valid for register level k; bit 3 is the output register.
  logic [3:0]  vld_pipe_q, vld_pipe_d;

  logic        s1_sign_q, s1_sign_d;
  logic [31:0] s1_mag_q, s1_mag_d;

  logic        s2_sign_q, s2_sign_d;
  logic        s2_zero_q, s2_zero_d;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic [30:0] s2_norm_q, s2_norm_d;

  logic        s3_sign_q, s3_sign_d;
  logic        s3_zero_q, s3_zero_d;
  logic [7:0]  s3_exp_q, s3_exp_d;
  logic        s3_carry_q, s3_carry_d;
  logic [22:0] s3_frac_q, s3_frac_d;

  logic [31:0] y_q, y_d;

  logic [4:0]  lz;
  logic        lz_found;
  logic [22:0] frac;
  logic        guard, sticky, round_up;

  assign stall   = vld_pipe_q[3] & ~y_ready;
  assign x_ready = ~stall;
  assign y       = y_q;
  assign y_valid = vld_pipe_q[3];

  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!lz_found && s1_mag_q[i]) begin
        lz       = 5'(31 - i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    frac     = s2_norm_q[30:8];
    guard    = s2_norm_q[7];
    sticky   = |s2_norm_q[6:0];
    round_up = (ROUND_MODE == 0) && guard && (sticky || frac[0]);
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_exp_d   = s2_exp_q;
    s2_norm_d  = s2_norm_q;
    s3_sign_d  = s3_sign_q;
    s3_zero_d  = s3_zero_q;
    s3_exp_d   = s3_exp_q;
    s3_carry_d = s3_carry_q;
    s3_frac_d  = s3_frac_q;
    y_d        = y_q;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[2:0], x_valid};
      // -x of 0x80000000 wraps to itself, which reads correctly as unsigned 2^31
      s1_sign_d  = x[31];
      s1_mag_d   = x[31] ? (~x + 32'd1) : x;

      s2_sign_d  = s1_sign_q;
      s2_zero_d  = (s1_mag_q == 32'd0);
      s2_exp_d   = 8'd158 - 8'(lz);
      s2_norm_d  = 31'(s1_mag_q << lz);

      s3_sign_d  = s2_sign_q;
      s3_zero_d  = s2_zero_q;
      s3_exp_d   = s2_exp_q;
      {s3_carry_d, s3_frac_d} = {1'b0, frac} + 24'(round_up);

      // carry leaves frac at zero and bumps the exponent; 158 max means no overflow
      y_d = s3_zero_q ? 32'h0 : {s3_sign_q, s3_exp_q + 8'(s3_carry_q), s3_frac_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_norm_q  <= '0;
      s3_sign_q  <= 1'b0;
      s3_zero_q  <= 1'b0;
      s3_exp_q   <= '0;
      s3_carry_q <= 1'b0;
      s3_frac_q  <= '0;
      y_q        <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_exp_q   <= s2_exp_d;
      s2_norm_q  <= s2_norm_d;
      s3_sign_q  <= s3_sign_d;
      s3_zero_q  <= s3_zero_d;
      s3_exp_q   <= s3_exp_d;
      s3_carry_q <= s3_carry_d;
      s3_frac_q  <= s3_frac_d;
      y_q        <= y_d;
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe: one instance per rounding mode, shared handshake inputs.
// Expected floats come from spec constants or an arithmetic reference model.
module tb_itof_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, x_valid, y_ready;
  logic [31:0] x;
  logic        xr0, xr1, yv0, yv1;
  logic [31:0] y0, y1;
  logic [31:0] drv_e0, drv_e1;

  itof_pipe #(.ROUND_MODE(0)) dut_rne (
    .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .x_ready(xr0),
    .y(y0), .y_valid(yv0), .y_ready(y_ready)
  );

  itof_pipe #(.ROUND_MODE(1)) dut_rz (
    .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .x_ready(xr1),
    .y(y1), .y_valid(yv1), .y_ready(y_ready)
  );

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    int          acc;
    int          snap;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, stall_cnt = 0;
  bit   rnd_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact binary scaling of |x| to a 24-bit significand, then rounding by remainder.
  function automatic logic [31:0] ref_cvt(input logic [31:0] xi, input int rm);
    longint v, m, q, r, half;
    int     e, sh;
    logic   s;
    v = longint'($signed(xi));
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      r    = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rm == 0 && (r > half || (r == half && (q % 2) == 1))) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), 23'(q & 64'h7FFFFF)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples on the falling edge, i.e. the handshake state the next rising edge acts on.
  initial begin : monitor
    bit          prev_stall;
    logic [31:0] prev_y0, prev_y1;
    exp_t        e;
    prev_stall = 1'b0;
    prev_y0 = '0;
    prev_y1 = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        sbq.delete();
        prev_stall = 1'b0;
      end else begin
        chk("x_ready", {31'b0, xr0}, {31'b0, !(yv0 && !y_ready)});
        chk("x_ready_rz", {31'b0, xr1}, {31'b0, !(yv1 && !y_ready)});
        chk("y_valid_rz", {31'b0, yv1}, {31'b0, yv0});
        if (prev_stall) begin
          chk("y_hold", y0, prev_y0);
          chk("y_hold_rz", y1, prev_y1);
        end
        if (x_valid && xr0) sbq.push_back('{drv_e0, drv_e1, cyc, stall_cnt});
        if (yv0 && y_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %h, expected no result (cycle %0d)", y0, cyc);
          end else begin
            e = sbq.pop_front();
            chk("y_rne", y0, e.e0);
            chk("y_rz", y1, e.e1);
            // accept-sample to take-sample spans 4 counted edges for the 3-edge latency
            chk("latency", 32'(cyc - e.acc - (stall_cnt - e.snap)), 32'd4);
          end
        end
        prev_stall = yv0 && !y_ready;
        if (prev_stall) stall_cnt++;
        prev_y0 = y0;
        prev_y1 = y1;
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [31:0] e0, input logic [31:0] e1);
    int n;
    n = 0;
    x = v;
    drv_e0 = e0;
    drv_e1 = e1;
    x_valid = 1'b1;
    @(negedge clk);
    while (!xr0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!xr0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got x_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic send_model(input logic [31:0] v);
    send(v, ref_cvt(v, 0), ref_cvt(v, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    y_ready = 1'b1;
    while (sbq.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results, expected 0", sbq.size());
    end
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_y_valid"}, {31'b0, yv0}, 32'd0);
    chk({tag, "_y"}, y0, 32'h0);
    chk({tag, "_x_ready"}, {31'b0, xr0}, 32'd1);
    chk({tag, "_y_valid_rz"}, {31'b0, yv1}, 32'd0);
    chk({tag, "_y_rz"}, y1, 32'h0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int          k;
    case ($urandom_range(3))
      0: v = $urandom;
      1: v = $urandom_range(32'h01FF_FFFF) - 32'h0100_0000;
      2: begin
        k = $urandom_range(24, 30);
        v = (32'd1 << k) + $urandom_range(255) - 32'd128;
        if ($urandom_range(1) == 1) v = ~v + 32'd1;
      end
      default: begin
        case ($urandom_range(4))
          0: v = 32'h0;
          1: v = 32'h8000_0000;
          2: v = 32'h7FFF_FFFF;
          3: v = 32'hFFFF_FFFF;
          default: v = 32'h0000_0001;
        endcase
      end
    endcase
    return v;
  endfunction

  logic [31:0] dir_x  [11] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'd100, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'h00FF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'hFEFF_FFFD, 32'd2};
  logic [31:0] dir_e0 [11] = '{32'h0, 32'h3F80_0000, 32'hBF80_0000, 32'h42C8_0000, 32'h4F00_0000,
                               32'hCF00_0000, 32'h4B7F_FFFF, 32'h4B80_0000, 32'h4B80_0002,
                               32'hCB80_0002, 32'h4000_0000};
  logic [31:0] dir_e1 [11] = '{32'h0, 32'h3F80_0000, 32'hBF80_0000, 32'h42C8_0000, 32'h4EFF_FFFF,
                               32'hCF00_0000, 32'h4B7F_FFFF, 32'h4B80_0000, 32'h4B80_0001,
                               32'hCB80_0001, 32'h4000_0000};
  logic [31:0] int_f  [8]  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                               32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

  initial begin
    rstn = 1'b0;
    x_valid = 1'b0;
    x = '0;
    y_ready = 1'b1;
    drv_e0 = '0;
    drv_e1 = '0;
    rnd_done = 1'b0;
    idle(3);
    chk_idle_state("reset");
    rstn = 1'b1;

    for (int i = 0; i < 11; i++) send(dir_x[i], dir_e0[i], dir_e1[i]);
    drain();

    fork
      begin
        for (int i = 1; i <= 8; i++) send(32'(i), int_f[i-1], int_f[i-1]);
      end
      begin
        int n;
        n = 0;
        while (!yv0 && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        y_ready = 1'b0;
        #1;
        chk("bp_x_ready", {31'b0, xr0}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        y_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) send_model(rand_operand());
    rstn = 1'b0;
    idle(1);
    rstn = 1'b1;
    chk_idle_state("midreset");
    send(32'd2, 32'h4000_0000, 32'h4000_0000);
    drain();

    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send_model(rand_operand());
          if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          y_ready = ($urandom_range(3) != 0);
        end
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itof_pipe.md
Name: itof_pipe

Overview:
- Pipelined signed-integer to IEEE-754 single-precision converter. It is the inverse of the FPU's float-to-int conversion path.
- Sits in the FPU beside the other conversion units.
- Accepts one 32-bit two's-complement integer per cycle and returns the rounded float after a fixed 3-cycle latency.
- Valid/ready handshake on both sides. Backpressure stalls the whole pipe.

Parameters:
- ROUND_MODE, default 0, rounding mode. 0 = round to nearest, ties to even. 1 = truncate toward zero (magnitude chopped).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- x  input  32  signed two's-complement integer operand.
- x_valid  input  1  x is valid this cycle.
- x_ready  output  1  block accepts x this cycle.
- y  output  32  IEEE-754 single result: {sign, exp[7:0], frac[22:0]}.
- y_valid  output  1  y holds a result.
- y_ready  input  1  consumer takes y this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low. While rstn=0 at a clock edge:
  - all stage valid bits clear;
  - y <= 32'h0, y_valid <= 0.
  - x_ready is combinational and equals 1 whenever the pipe is not stalled, so it is 1 after reset.
- Reset mid-operation: all in-flight operands are discarded; no result for them ever appears.
- Stall: stall = y_valid & ~y_ready.
  - x_ready = ~stall.
  - When stall=1, every stage register holds.
  - When stall=0, all stages advance together.
  - Bubbles are not collapsed.
- Acceptance: an input is accepted on an edge where x_valid & x_ready. Otherwise a bubble (valid=0) enters stage 1.
- Latency: an input accepted at edge N with no stall appears on y with y_valid=1 after edge N+3. Each stall cycle adds one cycle.
- Throughput: 1 result per cycle when y_ready is held high.
- Ordering: strictly in-order; no drops and no duplicates under any y_ready pattern.
- Stage 1 (sign/magnitude): s = x[31]; mag[31:0] = s ? -x : x. For x = 32'h80000000, mag = 32'h80000000, interpreted as unsigned 2^31.
- Stage 2 (normalize):
  - lz = leading-zero count of mag (0..31).
  - norm = mag << lz, so norm[31] = 1 unless mag = 0.
  - e = 158 - lz, i.e. 127 + 31 - lz.
  - zero flag = (mag == 0).
- Stage 3 (round/pack):
  - frac = norm[30:8]; guard = norm[7]; sticky = |norm[6:0].
  - ROUND_MODE 0: round up iff guard & (sticky | frac[0]).
  - ROUND_MODE 1: never round up.
  - If rounding carries out of frac (frac all ones), then frac = 0 and e += 1. The maximum exponent is 158, so there is no overflow and no inf/NaN output.
  - Zero flag set: y = 32'h00000000 (+0.0; there is never a -0.0).
  - Otherwise y = {s, e[7:0], frac}.
- Exactness: |x| < 2^24 always converts exactly. No denormals are produced.
- Output register: y is held stable while stall=1. y keeps its last value when y_valid=0 (don't-care for checking).
- Simultaneous events: an input accept and an output take in the same cycle are both legal. Reset has priority over all handshakes.

Test Plan:
- Basic values, y_ready=1, back-to-back: x = 0, 1, -1, 100 -> y = 00000000, 3F800000, BF800000, 42C80000. Each appears 3 cycles after acceptance, one per cycle.
- Extremes: x = 7FFFFFFF -> 4F000000 (round carry bumps the exponent). x = 80000000 -> CF000000. x = 00FFFFFF -> 4B7FFFFF (exact).
- Rounding, ROUND_MODE=0: x = 01000001 -> 4B800000 (tie, stays even). x = 01000003 -> 4B800002 (tie, rounds up). x = FEFFFFFD (-16777219) -> CB800002.
- ROUND_MODE=1: x = 01000003 -> 4B800001. x = 7FFFFFFF -> 4EFFFFFF.
- Backpressure: stream 1..8 with y_ready held 0 for 5 cycles once y_valid rises:
  - x_ready drops in the same cycle stall asserts;
  - y is stable throughout the stall;
  - after release, results 1.0..8.0 arrive in order with none lost or repeated.
- Reset mid-stream: assert rstn=0 for 1 cycle with 3 operands in flight.
  - Next cycle: y_valid=0, y=0, x_ready=1.
  - No stale result ever appears.
  - A fresh x=2 yields 40000000 after 3 cycles.
